// File: rtl/rib_arbiter.sv
// rib_arbiter: registered round-robin bus arbiter for the RIB bus.
// Define RIB_ARB_LOCK_EN to add lock_i, which keeps the bus across acks.
module rib_arbiter #(
    parameter int NUM_MASTERS    = 4,
    parameter int ID_W           = 2,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_MASTERS-1:0] req_i,
    input  logic                   ack_i,
`ifdef RIB_ARB_LOCK_EN
    input  logic                   lock_i,
`endif
    output logic [NUM_MASTERS-1:0] grant_o,
    output logic [ID_W-1:0]        grant_id_o,
    output logic                   busy_o,
    output logic [NUM_MASTERS-1:0] hold_o,
    output logic                   timeout_o
);

    typedef enum logic {
        IDLE,
        OWN
    } state_t;

    localparam logic [7:0]      WD_LAST  = 8'(TIMEOUT_CYCLES - 1);
    localparam logic [ID_W-1:0] LAST_RST = ID_W'(NUM_MASTERS - 1);

    state_t                 state;
    state_t                 state_nxt;
    logic [NUM_MASTERS-1:0] grant;
    logic [NUM_MASTERS-1:0] grant_nxt;
    logic [ID_W-1:0]        owner;
    logic [ID_W-1:0]        owner_nxt;
    logic [ID_W-1:0]        last;
    logic [ID_W-1:0]        last_nxt;
    logic [7:0]             wd;
    logic [7:0]             wd_nxt;
    logic                   timeout;
    logic                   timeout_nxt;

    logic                   pick_found;
    logic [ID_W-1:0]        pick_id;
    int                     idx;

    logic                   owner_req;
    logic                   lock_hold;
    logic                   release_now;

    // Owner still requesting; a dropped level means the owner abandoned.
    assign owner_req = |(req_i & grant);

`ifdef RIB_ARB_LOCK_EN
    assign lock_hold = lock_i;
`else
    assign lock_hold = 1'b0;
`endif

    // Unlocked ack or abandon frees the bus without a timeout pulse.
    assign release_now = !owner_req || (ack_i && !lock_hold);

    // Round-robin search starting just after the previous owner.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        idx        = 0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            idx = int'(last) + i;
            if (idx >= NUM_MASTERS) begin
                idx = idx - NUM_MASTERS;
            end
            if (!pick_found && req_i[idx]) begin
                pick_found = 1'b1;
                pick_id    = ID_W'(idx);
            end
        end
    end

    // Next-state logic: grant in IDLE, release or keep in OWN.
    always_comb begin
        state_nxt   = state;
        grant_nxt   = grant;
        owner_nxt   = owner;
        last_nxt    = last;
        wd_nxt      = wd;
        timeout_nxt = 1'b0;
        unique case (state)
            IDLE: begin
                if (pick_found) begin
                    state_nxt = OWN;
                    grant_nxt = NUM_MASTERS'(1) << pick_id;
                    owner_nxt = pick_id;
                    last_nxt  = pick_id;
                    wd_nxt    = '0;
                end
            end
            OWN: begin
                if (release_now) begin
                    state_nxt = IDLE;
                    grant_nxt = '0;
                    owner_nxt = '0;
                    wd_nxt    = '0;
                end else if (ack_i) begin
                    // Locked ack: keep the bus and restart the watchdog.
                    wd_nxt = '0;
                end else if (wd == WD_LAST) begin
                    state_nxt   = IDLE;
                    grant_nxt   = '0;
                    owner_nxt   = '0;
                    wd_nxt      = '0;
                    timeout_nxt = 1'b1;
                end else begin
                    wd_nxt = wd + 8'd1;
                end
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            grant   <= '0;
            owner   <= '0;
            last    <= LAST_RST;
            wd      <= '0;
            timeout <= 1'b0;
        end else begin
            state   <= state_nxt;
            grant   <= grant_nxt;
            owner   <= owner_nxt;
            last    <= last_nxt;
            wd      <= wd_nxt;
            timeout <= timeout_nxt;
        end
    end

    assign grant_o    = grant;
    assign grant_id_o = owner;
    assign busy_o     = (state == OWN);
    assign hold_o     = req_i & ~grant;
    assign timeout_o  = timeout;

endmodule

// File: tb/tb_rib_arbiter.sv
// tb_rib_arbiter: directed and randomized checks of rib_arbiter
// against an owner/age reference model.
module tb_rib_arbiter;

    localparam int N   = 4;
    localparam int IDW = 2;
    localparam int TO  = 16;
    localparam int VW  = 2 * N + IDW + 2;
`ifdef RIB_ARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic           ack;
    logic           lock;
    logic [N-1:0]   grant;
    logic [IDW-1:0] gid;
    logic           busy;
    logic [N-1:0]   hold;
    logic           tout;

    int n_pass   = 0;
    int n_checks = 0;

    // reference model: current owner (-1 none), last owner, cycles owned
    int m_owner;
    int m_last;
    int m_age;
    bit m_to;

    rib_arbiter #(
        .NUM_MASTERS   (N),
        .ID_W          (IDW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_i     (req),
        .ack_i     (ack),
`ifdef RIB_ARB_LOCK_EN
        .lock_i    (lock),
`endif
        .grant_o   (grant),
        .grant_id_o(gid),
        .busy_o    (busy),
        .hold_o    (hold),
        .timeout_o (tout)
    );

    always #5 clk = ~clk;

    task automatic model_step();
        int c;
        m_to = 1'b0;
        if (rst) begin
            m_owner = -1;
            m_last  = N - 1;
            m_age   = 0;
        end else if (m_owner < 0) begin
            for (int k = 1; k <= N; k++) begin
                c = (m_last + k) % N;
                if (req[c]) begin
                    m_owner = c;
                    m_last  = c;
                    m_age   = 1;
                    break;
                end
            end
        end else if (!req[m_owner] || (ack && !(LOCK_EN && lock))) begin
            m_owner = -1;
        end else if (ack) begin
            m_age = 1;
        end else if (m_age == TO) begin
            m_owner = -1;
            m_to    = 1'b1;
        end else begin
            m_age++;
        end
    endtask

    function automatic logic [VW-1:0] exp_vec();
        logic [N-1:0]   g;
        logic [IDW-1:0] id;
        g  = '0;
        id = '0;
        if (m_owner >= 0) begin
            g  = N'(1) << m_owner;
            id = IDW'(m_owner);
        end
        return {g, id, (m_owner >= 0), req & ~g, m_to};
    endfunction

    function automatic logic [VW-1:0] dut_vec();
        return {grant, gid, busy, hold, tout};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req  = '0;
        ack  = 1'b0;
        lock = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        req  = 4'b0101;
        ack  = 1'b1;
        lock = 1'b0;
        tick();
        tick();
        if ({grant, gid, busy, tout} !== '0 || hold !== 4'b0101) begin
            $display("FAIL reset_out: got g=%b id=%0d b=%b t=%b h=%b want 0/0/0/0/0101",
                     grant, gid, busy, tout, hold);
        end else n_pass++;
        n_checks++;
        rst = 1'b0;
        req = 4'b0001;
        ack = 1'b0;
        tick();
        if (grant !== 4'b0001 || gid !== 2'd0 || busy !== 1'b1 || hold !== 4'b0000) begin
            $display("FAIL first_grant: got g=%b id=%0d b=%b h=%b want 0001/0/1/0000",
                     grant, gid, busy, hold);
        end else n_pass++;
        n_checks++;
        if (dut_vec() !== exp_vec()) begin
            $display("FAIL first_vec: got %h want %h", dut_vec(), exp_vec());
        end else n_pass++;
        n_checks++;
        ack = 1'b1;
        tick();
        if (grant !== 4'b0000 || busy !== 1'b0) begin
            $display("FAIL ack_release: got g=%b b=%b want 0000/0", grant, busy);
        end else n_pass++;
        n_checks++;
        ack = 1'b0;
        req = '0;
        tick();
    endtask

    task automatic test_rotation();
        int order[5];
        int want[5];
        int n_own;
        int gap;
        logic [N-1:0] prev;
        want = '{0, 1, 2, 3, 0};
        order = '{default: -1};
        n_own = 0;
        gap = 0;
        prev = '0;
        do_reset();
        req = 4'b1111;
        for (int c = 0; c < 15; c++) begin
            ack = (c % 3 == 2);
            tick();
            if (dut_vec() !== exp_vec()) begin
                $display("FAIL rot_vec c%0d: got %h want %h", c, dut_vec(), exp_vec());
            end else n_pass++;
            n_checks++;
            if (grant != 0 && prev == 0) begin
                if (n_own > 0) begin
                    if (gap !== 1) begin
                        $display("FAIL rot_gap c%0d: got %0d want 1", c, gap);
                    end else n_pass++;
                    n_checks++;
                end
                if (n_own < 5) order[n_own] = int'(gid);
                n_own++;
                gap = 0;
            end else if (grant == 0) begin
                gap++;
            end
            prev = grant;
        end
        for (int i = 0; i < 5; i++) begin
            if (order[i] !== want[i]) begin
                $display("FAIL rot_order[%0d]: got %0d want %0d", i, order[i], want[i]);
            end else n_pass++;
            n_checks++;
        end
        ack = 1'b0;
        req = '0;
        tick();
        tick();
    endtask

    task automatic test_timeout();
        int owned;
        int pulses;
        do_reset();
        req = 4'b0100;
        tick();
        req = 4'b1100;
        owned = 1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (dut_vec() !== exp_vec()) begin
                $display("FAIL to_vec i%0d: got %h want %h", i, dut_vec(), exp_vec());
            end else n_pass++;
            n_checks++;
            if (tout) pulses++;
            if (grant == 4'b0100) owned++;
            else break;
        end
        if (owned !== TO || tout !== 1'b1 || grant !== 4'b0000) begin
            $display("FAIL to_release: got owned=%0d t=%b g=%b want %0d/1/0000",
                     owned, tout, grant, TO);
        end else n_pass++;
        n_checks++;
        tick();
        if (tout !== 1'b0 || grant !== 4'b1000 || gid !== 2'd3) begin
            $display("FAIL to_next: got t=%b g=%b id=%0d want 0/1000/3", tout, grant, gid);
        end else n_pass++;
        n_checks++;
        if (pulses !== 1) begin
            $display("FAIL to_pulses: got %0d want 1", pulses);
        end else n_pass++;
        n_checks++;
        ack = 1'b1;
        req = '0;
        tick();
        ack = 1'b0;
        tick();
    endtask

    task automatic test_ack_at_expiry();
        do_reset();
        req = 4'b0001;
        tick();
        for (int i = 0; i < TO - 1; i++) begin
            tick();
        end
        if (grant !== 4'b0001 || tout !== 1'b0) begin
            $display("FAIL exp_hold: got g=%b t=%b want 0001/0", grant, tout);
        end else n_pass++;
        n_checks++;
        ack = 1'b1;
        tick();
        ack = 1'b0;
        if (grant !== 4'b0000 || tout !== 1'b0) begin
            $display("FAIL exp_ack: got g=%b t=%b want 0000/0", grant, tout);
        end else n_pass++;
        n_checks++;
        if (dut_vec() !== exp_vec()) begin
            $display("FAIL exp_vec: got %h want %h", dut_vec(), exp_vec());
        end else n_pass++;
        n_checks++;
        req = '0;
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 4'b0010;
        tick();
        for (int i = 0; i < 4; i++) tick();
        if (grant !== 4'b0010) begin
            $display("FAIL mid_own: got g=%b want 0010", grant);
        end else n_pass++;
        n_checks++;
        rst = 1'b1;
        req = 4'b0110;
        tick();
        if (grant !== 4'b0000 || busy !== 1'b0 || tout !== 1'b0) begin
            $display("FAIL mid_rst: got g=%b b=%b t=%b want 0000/0/0", grant, busy, tout);
        end else n_pass++;
        n_checks++;
        rst = 1'b0;
        tick();
        if (grant !== 4'b0010 || gid !== 2'd1) begin
            $display("FAIL mid_regrant: got g=%b id=%0d want 0010/1", grant, gid);
        end else n_pass++;
        n_checks++;
        req = '0;
        tick();
        tick();
    endtask

`ifdef RIB_ARB_LOCK_EN
    task automatic test_lock();
        do_reset();
        req = 4'b0011;
        tick();
        for (int k = 0; k < 2; k++) begin
            lock = 1'b1;
            ack  = 1'b1;
            tick();
            if (grant !== 4'b0001 || busy !== 1'b1) begin
                $display("FAIL lock_hold%0d: got g=%b b=%b want 0001/1", k, grant, busy);
            end else n_pass++;
            n_checks++;
            ack = 1'b0;
            tick();
        end
        lock = 1'b0;
        ack  = 1'b1;
        tick();
        ack = 1'b0;
        if (grant !== 4'b0000) begin
            $display("FAIL lock_release: got g=%b want 0000", grant);
        end else n_pass++;
        n_checks++;
        tick();
        if (grant !== 4'b0010 || gid !== 2'd1) begin
            $display("FAIL lock_next: got g=%b id=%0d want 0010/1", grant, gid);
        end else n_pass++;
        n_checks++;
        req = '0;
        ack = 1'b1;
        tick();
        ack = 1'b0;
        tick();
    endtask
`endif

    task automatic test_random();
        int ack_div;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            ack_div = (c / 500) % 2 == 0 ? 3 : 40;
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
            end
            ack  = ($urandom_range(0, ack_div) == 0);
            lock = $urandom_range(0, 1) == 1;
            rst  = ($urandom_range(0, 299) == 0);
            tick();
            if (dut_vec() !== exp_vec()) begin
                $display("FAIL rand_vec c%0d: got %h want %h", c, dut_vec(), exp_vec());
            end else n_pass++;
            n_checks++;
        end
        rst = 1'b0;
        req = '0;
        ack = 1'b0;
        lock = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        req     = '0;
        ack     = 1'b0;
        lock    = 1'b0;
        m_owner = -1;
        m_last  = N - 1;
        m_age   = 0;
        m_to    = 1'b0;
        test_reset();
        test_rotation();
        test_timeout();
        test_ack_at_expiry();
        test_reset_mid();
`ifdef RIB_ARB_LOCK_EN
        test_lock();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
